// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and index helper for the memory arbiter
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT,
    LOCK  = ST_LOCK
  } arb_state_e;

  function automatic int next_index(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first requester at or after p
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] p,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scanning from the farthest offset back toward p lets the nearest requester win last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(p) + k) % N]) begin
        idx   = IDX_W'((int'(p) + k) % N);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one RAM port among N cores, with atomic lock
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int N_CORES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CORES-1:0]          core_read,
  input  logic [N_CORES-1:0]          core_write,
  input  logic [N_CORES-1:0]          core_atomic,
  input  logic [N_CORES*ADDR_W-1:0]   core_addr,
  input  logic [N_CORES*DATA_W-1:0]   core_data_w,
  output logic [DATA_W-1:0]           core_data_r,
  output logic [N_CORES-1:0]          core_wait,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data_w,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic                        mem_atomic,
  input  logic [DATA_W-1:0]           mem_data_r,
  input  logic                        mem_wait
);

  localparam int IDX_W = $clog2(N_CORES);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [IDX_W-1:0]   p_q, p_d;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   p_after_g;
  logic               pick_valid;
  logic [N_CORES-1:0] req;
  logic               req_g;
  logic               atomic_g;
  logic               done_g;

  assign req         = core_read | core_write;
  assign req_g       = req[g_q];
  assign atomic_g    = core_atomic[g_q];
  assign done_g      = req_g & ~mem_wait;
  assign p_after_g   = IDX_W'(next_index(int'(g_q), N_CORES));
  assign core_data_r = mem_data_r;

  rr_pick #(.N(N_CORES), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .p     (p_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    mem_addr   = '0;
    mem_data_w = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_atomic = 1'b0;
    core_wait  = req;
    if (state_q != IDLE) begin
      mem_addr       = core_addr[int'(g_q)*ADDR_W +: ADDR_W];
      mem_data_w     = core_data_w[int'(g_q)*DATA_W +: DATA_W];
      mem_read       = core_read[g_q];
      mem_write      = core_write[g_q];
      mem_atomic     = atomic_g;
      core_wait[g_q] = req_g & mem_wait;
    end
  end

  // A withdrawn grant leaves p alone so the same core is not skipped over.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          g_d     = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req_g) begin
          state_d = IDLE;
        end else if (done_g) begin
          if (atomic_g) begin
            state_d = LOCK;
          end else begin
            state_d = IDLE;
            p_d     = p_after_g;
          end
        end
      end
      LOCK: begin
        if (!atomic_g && (done_g || !req_g)) begin
          state_d = IDLE;
          p_d     = p_after_g;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against an ownership model
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    core_read, core_write, core_atomic;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_data_w;
  logic [DW-1:0]   core_data_r;
  logic [N-1:0]    core_wait;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data_w;
  logic            mem_read, mem_write, mem_atomic;
  logic [DW-1:0]   mem_data_r;
  logic            mem_wait;

  int n_checks = 0;
  int n_errors = 0;

  // Model: which core owns the RAM port (-1 = nobody), whether it holds a lock, and the fairness pointer.
  int m_owner  = -1;
  bit m_locked = 1'b0;
  int m_ptr    = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .N_CORES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .core_read   (core_read),
    .core_write  (core_write),
    .core_atomic (core_atomic),
    .core_addr   (core_addr),
    .core_data_w (core_data_w),
    .core_data_r (core_data_r),
    .core_wait   (core_wait),
    .mem_addr    (mem_addr),
    .mem_data_w  (mem_data_w),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_atomic  (mem_atomic),
    .mem_data_r  (mem_data_r),
    .mem_wait    (mem_wait)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_core(input int i, input bit rd, input bit wr, input bit at,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_read[i]             = rd;
    core_write[i]            = wr;
    core_atomic[i]           = at;
    core_addr[i*AW +: AW]    = a;
    core_data_w[i*DW +: DW]  = d;
  endtask

  task automatic clear_cores();
    for (int i = 0; i < N; i++) set_core(i, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_outputs(input string ctx);
    logic [N-1:0]  req, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          er, ewr, eat;
    req = core_read | core_write;
    ew  = req;
    ea  = '0;
    ed  = '0;
    er  = 1'b0;
    ewr = 1'b0;
    eat = 1'b0;
    if (m_owner >= 0) begin
      ea  = core_addr[m_owner*AW +: AW];
      ed  = core_data_w[m_owner*DW +: DW];
      er  = core_read[m_owner];
      ewr = core_write[m_owner];
      eat = core_atomic[m_owner];
      ew[m_owner] = req[m_owner] & mem_wait;
    end
    chk_eq({ctx, ".mem_read"},    mem_read,    er);
    chk_eq({ctx, ".mem_write"},   mem_write,   ewr);
    chk_eq({ctx, ".mem_atomic"},  mem_atomic,  eat);
    chk_eq({ctx, ".mem_addr"},    mem_addr,    ea);
    chk_eq({ctx, ".mem_data_w"},  mem_data_w,  ed);
    chk_eq({ctx, ".core_wait"},   core_wait,   ew);
    chk_eq({ctx, ".core_data_r"}, core_data_r, mem_data_r);
  endtask

  task automatic model_update();
    logic [N-1:0] req;
    bit r, done, at;
    req = core_read | core_write;
    if (rst) begin
      m_owner  = -1;
      m_locked = 1'b0;
      m_ptr    = 0;
      return;
    end
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
      m_locked = 1'b0;
    end else begin
      r    = req[m_owner];
      done = r && !mem_wait;
      at   = core_atomic[m_owner];
      if (!m_locked) begin
        if (!r) begin
          m_owner = -1;
        end else if (done && at) begin
          m_locked = 1'b1;
        end else if (done) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end else if ((done || !r) && !at) begin
        m_ptr    = (m_owner + 1) % N;
        m_owner  = -1;
        m_locked = 1'b0;
      end
    end
  endtask

  task automatic run_cycle(input string ctx);
    #1;
    check_outputs(ctx);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  logic [AW-1:0] order_addr [3];
  int kind;

  initial begin
    rst         = 1'b1;
    core_read   = '0;
    core_write  = '0;
    core_atomic = '0;
    core_addr   = '0;
    core_data_w = '0;
    mem_data_r  = 32'h1234_5678;
    mem_wait    = 1'b0;
    @(negedge clk);
    set_core(3, 1'b1, 1'b0, 1'b0, 16'h0300, '0);
    @(posedge clk);
    model_update();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_eq("reset.mem_read", mem_read, 1'b0);
    chk_eq("reset.core_wait", core_wait, 4'b1000);
    run_cycle("reset_idle");
    run_cycle("reset_grant");
    clear_cores();
    run_cycle("reset_done");

    // Contention from a fresh reset: cores 0, 2, 3 write together.
    rst = 1'b1;
    run_cycle("rst2");
    rst = 1'b0;
    order_addr[0] = 16'h0A00;
    order_addr[1] = 16'h0A02;
    order_addr[2] = 16'h0A03;
    set_core(0, 1'b0, 1'b1, 1'b0, order_addr[0], 32'hD0);
    set_core(2, 1'b0, 1'b1, 1'b0, order_addr[1], 32'hD2);
    set_core(3, 1'b0, 1'b1, 1'b0, order_addr[2], 32'hD3);
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c % 2 == 1) chk_eq("contend.order", mem_addr, order_addr[c/2]);
      run_cycle("contend");
    end
    clear_cores();

    // Single read by core1 stalled twice by the RAM.
    mem_data_r = 32'hCAFE_0001;
    mem_wait   = 1'b1;
    set_core(1, 1'b1, 1'b0, 1'b0, 16'h0010, '0);
    run_cycle("read.idle");
    #1;
    chk_eq("read.mem_read", mem_read, 1'b1);
    run_cycle("read.stall");
    mem_wait = 1'b0;
    #1;
    chk_eq("read.data", core_data_r, 32'hCAFE_0001);
    chk_eq("read.wait_low", core_wait[1], 1'b0);
    run_cycle("read.done");
    clear_cores();
    run_cycle("read.after");

    // Move the pointer to 3, then cores 0 and 1 race: core0 must win.
    set_core(2, 1'b0, 1'b1, 1'b0, 16'h0B02, 32'h22);
    run_cycle("wrap.pre_idle");
    run_cycle("wrap.pre_grant");
    clear_cores();
    run_cycle("wrap.gap");
    set_core(0, 1'b1, 1'b0, 1'b0, 16'h0C00, '0);
    set_core(1, 1'b1, 1'b0, 1'b0, 16'h0C01, '0);
    run_cycle("wrap.idle");
    #1;
    chk_eq("wrap.first", mem_addr, 16'h0C00);
    run_cycle("wrap.grant");
    clear_cores();
    run_cycle("wrap.after");

    // Atomic read-modify-write by core2 while core0 keeps asking.
    set_core(2, 1'b1, 1'b0, 1'b1, 16'h0020, '0);
    run_cycle("atom.idle");
    set_core(0, 1'b0, 1'b1, 1'b0, 16'h0040, 32'h99);
    run_cycle("atom.read");
    set_core(2, 1'b0, 1'b1, 1'b1, 16'h0020, 32'h5);
    #1;
    chk_eq("atom.core0_held", core_wait[0], 1'b1);
    chk_eq("atom.wdata", mem_data_w, 32'h5);
    run_cycle("atom.write");
    set_core(2, 1'b0, 1'b1, 1'b0, 16'h0020, 32'h5);
    #1;
    chk_eq("atom.core0_held2", core_wait[0], 1'b1);
    run_cycle("atom.release");
    clear_cores();
    set_core(0, 1'b0, 1'b1, 1'b0, 16'h0040, 32'h99);
    run_cycle("atom.idle2");
    #1;
    chk_eq("atom.core0_grant", mem_addr, 16'h0040);
    run_cycle("atom.core0");
    clear_cores();
    run_cycle("atom.after");

    // Reset while core1 holds a lock; core3 is left pending.
    set_core(1, 1'b1, 1'b0, 1'b1, 16'h0030, '0);
    set_core(3, 1'b1, 1'b0, 1'b0, 16'h0070, '0);
    run_cycle("rlock.idle");
    run_cycle("rlock.grant");
    run_cycle("rlock.lock");
    rst = 1'b1;
    set_core(1, 1'b0, 1'b0, 1'b0, '0, '0);
    run_cycle("rlock.reset");
    rst = 1'b0;
    #1;
    chk_eq("rlock.mem_read", mem_read, 1'b0);
    chk_eq("rlock.mem_write", mem_write, 1'b0);
    chk_eq("rlock.wait", core_wait, 4'b1000);
    run_cycle("rlock.idle2");
    #1;
    chk_eq("rlock.core3", mem_addr, 16'h0070);
    run_cycle("rlock.core3");
    clear_cores();
    run_cycle("rlock.after");

    // Core2 withdraws while stalled; the pointer must stay at 0.
    mem_wait = 1'b1;
    set_core(2, 1'b1, 1'b0, 1'b0, 16'h0050, '0);
    run_cycle("wd.idle");
    run_cycle("wd.stall");
    clear_cores();
    run_cycle("wd.drop");
    #1;
    chk_eq("wd.no_read", mem_read, 1'b0);
    mem_wait = 1'b0;
    set_core(1, 1'b1, 1'b0, 1'b0, 16'h0061, '0);
    set_core(3, 1'b1, 1'b0, 1'b0, 16'h0063, '0);
    run_cycle("wd.idle2");
    #1;
    chk_eq("wd.ptr_kept", mem_addr, 16'h0061);
    run_cycle("wd.grant");
    clear_cores();
    run_cycle("wd.after");

    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0) begin
          kind = int'($urandom_range(5));
          set_core(i, (kind == 1 || kind == 3), (kind == 2 || kind == 3),
                   ($urandom_range(3) == 0), AW'($urandom_range(255)), $urandom);
        end
      end
      mem_wait   = ($urandom_range(2) == 0);
      mem_data_r = $urandom;
      rst        = ($urandom_range(199) == 0);
      run_cycle("rnd");
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
